// File: rtl/cbus_rr_arbiter_pkg.sv
// Shared types for the CBus round-robin arbiter: bus request/response structs,
// arbiter state encoding and the default watchdog limit.
package cbus_rr_arbiter_pkg;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_t;

    localparam int CBUS_ARB_TIMEOUT_DEFAULT = 1024;

    // Modulo increment with an explicit compare so non-power-of-two counts wrap correctly.
    function automatic int rr_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cbus_rr_arbiter_if.sv
// Bundle of requester-side and memory-side CBus signals seen by the arbiter.
// slave = arbiter view, master = environment view.
interface cbus_rr_arbiter_if #(
    parameter int NUM_INPUTS = 2
);
    import cbus_rr_arbiter_pkg::*;

    localparam int IDX_W = $clog2(NUM_INPUTS);

    cbus_req_t  [NUM_INPUTS-1:0] ireqs;
    cbus_resp_t [NUM_INPUTS-1:0] iresps;
    cbus_req_t                   oreq;
    cbus_resp_t                  oresp;
    logic       [IDX_W-1:0]      grant_idx;
    logic                        busy;
    logic                        err_timeout;

    modport slave (
        input  ireqs, oresp,
        output iresps, oreq, grant_idx, busy, err_timeout
    );

    modport master (
        output ireqs, oresp,
        input  iresps, oreq, grant_idx, busy, err_timeout
    );

endinterface

// File: rtl/cbus_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of valid scanning upward from
// ptr with wrap-around.
module cbus_rr_arbiter_rr_pick #(
    parameter  int NUM_INPUTS = 2,
    localparam int IDX_W      = $clog2(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS-1:0] valid,
    input  logic [IDX_W-1:0]      ptr,
    output logic                  found,
    output logic [IDX_W-1:0]      idx
);

    int cand;

    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = 0;
        // Scan from the farthest offset down so the closest-to-ptr requester is written last and wins.
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_INPUTS) cand = cand - NUM_INPUTS;
            if (valid[cand]) begin
                found = 1'b1;
                idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// Round-robin arbiter sharing one CBus master port; ownership is held until the last beat.
// Optional watchdog abort enabled by defining CBUS_ARB_TIMEOUT_EN.
module cbus_rr_arbiter
    import cbus_rr_arbiter_pkg::*;
#(
    parameter int NUM_INPUTS     = 2,
    parameter int TIMEOUT_CYCLES = CBUS_ARB_TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    cbus_rr_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_INPUTS);

    if (NUM_INPUTS < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("cbus_rr_arbiter: NUM_INPUTS and TIMEOUT_CYCLES must both be >= 2");
    end

    arb_state_t                  state_q, state_d;
    logic       [IDX_W-1:0]      grant_q, grant_d;
    logic       [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic       [IDX_W-1:0]      pick_idx;
    logic       [NUM_INPUTS-1:0] req_valid;
    logic                        pick_found;
    logic                        txn_end;
    logic                        release_bus;
    cbus_req_t                   oreq_c;
    cbus_resp_t [NUM_INPUTS-1:0] iresps_c;

`ifdef CBUS_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             timeout_hit;
`endif

    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) req_valid[i] = bus.ireqs[i].valid;
    end

    cbus_rr_arbiter_rr_pick #(
        .NUM_INPUTS (NUM_INPUTS)
    ) u_rr_pick (
        .valid (req_valid),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        oreq_c      = '0;
        iresps_c    = '0;
        txn_end     = 1'b0;
        release_bus = 1'b0;
`ifdef CBUS_ARB_TIMEOUT_EN
        cnt_d       = '0;
        err_d       = 1'b0;
        timeout_hit = 1'b0;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                oreq_c            = bus.ireqs[grant_q];
                iresps_c[grant_q] = bus.oresp;
                // A requester dropping valid mid-transaction is treated like a normal end.
                txn_end     = (bus.oresp.ready && bus.oresp.last) || !bus.ireqs[grant_q].valid;
                release_bus = txn_end;
`ifdef CBUS_ARB_TIMEOUT_EN
                cnt_d       = bus.oresp.ready ? '0 : cnt_q + 1'b1;
                timeout_hit = !bus.oresp.ready && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
                err_d       = timeout_hit;
                release_bus = txn_end || timeout_hit;
`endif
                if (release_bus) begin
                    state_d  = ARB_IDLE;
                    rr_ptr_d = IDX_W'(rr_inc(int'(grant_q), NUM_INPUTS));
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef CBUS_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign bus.err_timeout = err_q;
`else
    assign bus.err_timeout = 1'b0;
`endif

    assign bus.oreq      = oreq_c;
    assign bus.iresps    = iresps_c;
    assign bus.grant_idx = grant_q;
    assign bus.busy      = (state_q == ARB_BUSY);

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Self-checking bench for cbus_rr_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level ownership model.
module tb_cbus_rr_arbiter;
    import cbus_rr_arbiter_pkg::*;

    localparam int N   = 2;
    localparam int TMO = 8;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    // Reference model: owner index (-1 = nobody), next-first requester, cycles since last ready.
    int m_owner;
    int m_ptr;
    int m_cnt;
    bit m_err;

    cbus_rr_arbiter_if #(.NUM_INPUTS(N)) bus ();

    cbus_rr_arbiter #(
        .NUM_INPUTS     (N),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock: compute the model's next state from the current inputs, then
    // return at the following falling edge where outputs are sampled.
    task automatic tick();
        int n_owner = m_owner;
        int n_ptr   = m_ptr;
        int n_cnt   = m_cnt;
        bit n_err   = 1'b0;
        if (!reset) begin
            n_owner = -1;
            n_ptr   = 0;
            n_cnt   = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                if (bus.ireqs[(m_ptr + k) % N].valid) begin
                    n_owner = (m_ptr + k) % N;
                    n_cnt   = 0;
                    break;
                end
            end
        end else begin
            bit done;
            bit tmo;
            done = (bus.oresp.ready && bus.oresp.last) || !bus.ireqs[m_owner].valid;
            tmo  = 1'b0;
`ifdef CBUS_ARB_TIMEOUT_EN
            tmo   = !bus.oresp.ready && (m_cnt == TMO - 1);
            n_cnt = bus.oresp.ready ? 0 : m_cnt + 1;
`endif
            if (done || tmo) begin
                n_owner = -1;
                n_ptr   = (m_owner + 1) % N;
                n_err   = tmo;
            end
        end
        @(posedge clk);
        m_owner = n_owner;
        m_ptr   = n_ptr;
        m_cnt   = n_cnt;
        m_err   = n_err;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.ireqs[0].valid = 1'b1;
        bus.ireqs[0].addr  = 32'h0000_1000;
        repeat (3) begin
            tick();
            n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
            n_checks++; if (bus.grant_idx !== '0) begin n_fail++; $display("FAIL reset_grant: got %0d want 0", bus.grant_idx); end
            n_checks++; if (bus.oreq.valid !== 1'b0) begin n_fail++; $display("FAIL reset_oreq_valid: got %b want 0", bus.oreq.valid); end
            n_checks++; if (bus.err_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.err_timeout); end
            for (int i = 0; i < N; i++) begin
                n_checks++; if (bus.iresps[i].ready !== 1'b0) begin n_fail++; $display("FAIL reset_iresp_ready[%0d]: got %b want 0", i, bus.iresps[i].ready); end
            end
        end
        bus.ireqs = '0;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        bus.ireqs[1].valid = 1'b1;
        bus.ireqs[1].addr  = 32'h8000_0000;
        bus.ireqs[1].len   = 8'd0;
        tick();
        n_checks++; if (bus.oreq.valid !== 1'b1 || bus.oreq.addr !== 32'h8000_0000) begin n_fail++; $display("FAIL single_fwd: got valid=%b addr=%h want 1/80000000", bus.oreq.valid, bus.oreq.addr); end
        n_checks++; if (bus.busy !== 1'b1 || bus.grant_idx !== 1'b1) begin n_fail++; $display("FAIL single_grant: got busy=%b idx=%0d want 1/1", bus.busy, bus.grant_idx); end
        repeat (2) begin
            tick();
            n_checks++; if (bus.oreq.valid !== 1'b1 || bus.iresps[0].ready !== 1'b0) begin n_fail++; $display("FAIL single_wait: got oreq.valid=%b iresp0.ready=%b want 1/0", bus.oreq.valid, bus.iresps[0].ready); end
        end
        tick();
        bus.oresp = '{ready: 1'b1, last: 1'b1, data: 32'hCAFE_F00D};
        #1;
        n_checks++; if (bus.iresps[1] !== bus.oresp) begin n_fail++; $display("FAIL single_resp1: got %h want %h", bus.iresps[1], bus.oresp); end
        n_checks++; if (bus.iresps[0].ready !== 1'b0) begin n_fail++; $display("FAIL single_resp0: got %b want 0", bus.iresps[0].ready); end
        tick();
        bus.ireqs = '0;
        bus.oresp = '0;
        #1;
        n_checks++; if (bus.busy !== 1'b0 || bus.oreq.valid !== 1'b0) begin n_fail++; $display("FAIL single_idle: got busy=%b valid=%b want 0/0", bus.busy, bus.oreq.valid); end
    endtask

    task automatic test_contention();
        int exp_busy [8] = '{1, 0, 1, 0, 1, 0, 1, 0};
        int exp_g    [8] = '{0, 0, 1, 0, 0, 0, 1, 0};
        for (int i = 0; i < N; i++) begin
            bus.ireqs[i].valid = 1'b1;
            bus.ireqs[i].addr  = 32'h1000 * (i + 1);
        end
        bus.oresp = '{ready: 1'b1, last: 1'b1, data: 32'h1234_5678};
        for (int c = 0; c < 8; c++) begin
            tick();
            n_checks++; if (bus.busy !== exp_busy[c][0]) begin n_fail++; $display("FAIL contention_busy[%0d]: got %b want %0d", c, bus.busy, exp_busy[c]); end
            if (exp_busy[c] == 1) begin
                n_checks++; if (int'(bus.grant_idx) != exp_g[c]) begin n_fail++; $display("FAIL contention_grant[%0d]: got %0d want %0d", c, bus.grant_idx, exp_g[c]); end
                n_checks++; if (bus.oreq.addr !== 32'h1000 * (exp_g[c] + 1)) begin n_fail++; $display("FAIL contention_addr[%0d]: got %h want %h", c, bus.oreq.addr, 32'h1000 * (exp_g[c] + 1)); end
                n_checks++; if (bus.iresps[exp_g[c]].ready !== 1'b1 || bus.iresps[1 - exp_g[c]].ready !== 1'b0) begin n_fail++; $display("FAIL contention_resp[%0d]: got owner=%b other=%b want 1/0", c, bus.iresps[exp_g[c]].ready, bus.iresps[1 - exp_g[c]].ready); end
            end
        end
        bus.ireqs = '0;
        bus.oresp = '0;
    endtask

    task automatic test_burst_lock();
        bus.ireqs[0].valid = 1'b1;
        bus.ireqs[0].len   = 8'd3;
        bus.ireqs[1].valid = 1'b1;
        tick();
        n_checks++; if (bus.busy !== 1'b1 || bus.grant_idx !== 1'b0) begin n_fail++; $display("FAIL burst_grant0: got busy=%b idx=%0d want 1/0", bus.busy, bus.grant_idx); end
        for (int b = 0; b < 4; b++) begin
            bus.oresp = '{ready: 1'b1, last: (b == 3), data: 32'hB000 + b};
            #1;
            n_checks++; if (bus.iresps[0].ready !== 1'b1 || bus.iresps[0].data !== 32'hB000 + b) begin n_fail++; $display("FAIL burst_beat[%0d]: got ready=%b data=%h want 1/%h", b, bus.iresps[0].ready, bus.iresps[0].data, 32'hB000 + b); end
            n_checks++; if (bus.iresps[1].ready !== 1'b0) begin n_fail++; $display("FAIL burst_other[%0d]: got %b want 0", b, bus.iresps[1].ready); end
            tick();
            n_checks++; if (bus.busy !== (b < 3)) begin n_fail++; $display("FAIL burst_hold[%0d]: got busy=%b want %b", b, bus.busy, b < 3); end
        end
        bus.oresp = '0;
        bus.ireqs[0].valid = 1'b0;
        tick();
        n_checks++; if (bus.busy !== 1'b1 || bus.grant_idx !== 1'b1) begin n_fail++; $display("FAIL burst_next: got busy=%b idx=%0d want 1/1", bus.busy, bus.grant_idx); end
        bus.oresp = '{ready: 1'b1, last: 1'b1, data: 32'h0};
        tick();
        bus.ireqs = '0;
        bus.oresp = '0;
    endtask

    task automatic test_reset_mid_burst();
        bus.ireqs[0].valid = 1'b1;
        bus.ireqs[0].len   = 8'd3;
        tick();
        bus.oresp = '{ready: 1'b1, last: 1'b0, data: 32'h5};
        repeat (2) tick();
        bus.oresp = '0;
        reset = 1'b0;
        tick();
        n_checks++; if (bus.oreq.valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL midreset_idle: got valid=%b busy=%b want 0/0", bus.oreq.valid, bus.busy); end
        n_checks++; if (bus.iresps[0].ready !== 1'b0) begin n_fail++; $display("FAIL midreset_resp: got %b want 0", bus.iresps[0].ready); end
        reset = 1'b1;
        bus.ireqs[1].valid = 1'b1;
        tick();
        n_checks++; if (bus.busy !== 1'b1 || bus.grant_idx !== 1'b0) begin n_fail++; $display("FAIL midreset_ptr: got busy=%b idx=%0d want 1/0", bus.busy, bus.grant_idx); end
        bus.ireqs = '0;
        tick();
    endtask

`ifdef CBUS_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bus.ireqs[0].valid = 1'b1;
        bus.ireqs[1].valid = 1'b1;
        bus.oresp = '0;
        for (int c = 1; c <= TMO; c++) begin
            tick();
            n_checks++; if (bus.busy !== 1'b1 || bus.grant_idx !== 1'b0 || bus.err_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_busy[%0d]: got busy=%b idx=%0d err=%b want 1/0/0", c, bus.busy, bus.grant_idx, bus.err_timeout); end
        end
        tick();
        n_checks++; if (bus.err_timeout !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse: got err=%b busy=%b want 1/0", bus.err_timeout, bus.busy); end
        tick();
        n_checks++; if (bus.err_timeout !== 1'b0 || bus.busy !== 1'b1 || bus.grant_idx !== 1'b1) begin n_fail++; $display("FAIL timeout_next: got err=%b busy=%b idx=%0d want 0/1/1", bus.err_timeout, bus.busy, bus.grant_idx); end
        bus.ireqs = '0;
        tick();
    endtask
`endif

    task automatic test_random();
        cbus_req_t  exp_req;
        cbus_resp_t exp_resp;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset = ($urandom_range(0, 299) != 0);
            for (int i = 0; i < N; i++) begin
                if (m_owner == i) begin
                    if ($urandom_range(0, 49) == 0) bus.ireqs[i].valid = 1'b0;
                end else begin
                    bus.ireqs[i].valid    = bus.ireqs[i].valid ? ($urandom_range(0, 9) < 8) : $urandom_range(0, 1);
                    bus.ireqs[i].is_write = 1'($urandom_range(0, 1));
                    bus.ireqs[i].addr     = $urandom;
                    bus.ireqs[i].len      = 8'($urandom_range(0, 3));
                    bus.ireqs[i].wdata    = $urandom;
                    bus.ireqs[i].wstrb    = 4'($urandom_range(0, 15));
                end
            end
            bus.oresp.ready = ($urandom_range(0, 99) < 40);
            bus.oresp.last  = 1'($urandom_range(0, 1));
            bus.oresp.data  = $urandom;
            #1;
            exp_req = (m_owner >= 0) ? bus.ireqs[m_owner] : '0;
            n_checks++; if (bus.busy !== (m_owner >= 0)) begin n_fail++; $display("FAIL rand_busy@%0d: got %b want %b", cyc, bus.busy, m_owner >= 0); end
            if (m_owner >= 0) begin
                n_checks++; if (int'(bus.grant_idx) != m_owner) begin n_fail++; $display("FAIL rand_grant@%0d: got %0d want %0d", cyc, bus.grant_idx, m_owner); end
            end
            n_checks++; if (bus.oreq !== exp_req) begin n_fail++; $display("FAIL rand_oreq@%0d: got %h want %h", cyc, bus.oreq, exp_req); end
            for (int i = 0; i < N; i++) begin
                exp_resp = (m_owner == i) ? bus.oresp : '0;
                n_checks++; if (bus.iresps[i] !== exp_resp) begin n_fail++; $display("FAIL rand_iresp[%0d]@%0d: got %h want %h", i, cyc, bus.iresps[i], exp_resp); end
            end
            n_checks++; if (bus.err_timeout !== m_err) begin n_fail++; $display("FAIL rand_err@%0d: got %b want %b", cyc, bus.err_timeout, m_err); end
            tick();
        end
        reset = 1'b1;
        bus.ireqs = '0;
        bus.oresp = '0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_owner  = -1;
        m_ptr    = 0;
        m_cnt    = 0;
        m_err    = 1'b0;
        reset    = 1'b0;
        bus.ireqs = '0;
        bus.oresp = '0;
        test_reset();
        test_single_read();
        test_contention();
        test_burst_lock();
        test_reset_mid_burst();
`ifdef CBUS_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
